// File: rtl/sample_pack.sv
// sample_pack: packs a BIL sample stream into {north-east neighbour, current sample}
// pairs, using a one-line (Nx*Nz) buffer to recall the previous line.
module sample_pack #(
   parameter int X_LEN      = 11,
   parameter int Y_LEN      = 5,
   parameter int Z_LEN      = 8,
   parameter int DATA_WIDTH = 12,
   parameter int LINE_DEPTH = 2048,
   parameter int ADDR_W     = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [X_LEN-1:0]      Nx,
   input  logic [Y_LEN-1:0]      Ny,
   input  logic [Z_LEN-1:0]      Nz,
   input  logic [DATA_WIDTH-1:0] s_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic [31:0]           data_o,
   output logic                  en_o,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic                  cfg_err_o
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t                 r_state;
   logic [X_LEN-1:0]       r_nx, r_x;
   logic [Y_LEN-1:0]       r_ny, r_y;
   logic [Z_LEN-1:0]       r_nz, r_z;
   logic [ADDR_W:0]        r_l;
   logic [ADDR_W-1:0]      r_a;
   logic [1:0]             r_drain;
   logic                   r_v1, r_m1;
   logic [DATA_WIDTH-1:0]  r_s1, r_q;
   logic [DATA_WIDTH-1:0]  r_mem [LINE_DEPTH];
   logic [X_LEN+Z_LEN-1:0] w_prod;
   logic [ADDR_W:0]        w_an;
   logic [ADDR_W-1:0]      w_ra;
   logic                   w_beat, w_legal, w_xw, w_zw, w_yw;

   assign s_ready_o = r_state == RUN;
   assign busy_o    = r_state == RUN || r_state == DRAIN;
   assign w_beat    = s_ready_o && s_valid_i;
   assign w_prod    = {{Z_LEN{1'b0}}, Nx} * {{X_LEN{1'b0}}, Nz};
   assign w_legal   = Nx != '0 && Ny != '0 && Nz != '0 && w_prod <= (X_LEN+Z_LEN)'(LINE_DEPTH);
   assign w_xw      = r_x == r_nx - X_LEN'(1);
   assign w_zw      = r_z == r_nz - Z_LEN'(1);
   assign w_yw      = r_y == r_ny - Y_LEN'(1);
   assign w_an      = {1'b0, r_a} + (ADDR_W+1)'(1);
   assign w_ra      = w_an == r_l ? '0 : w_an[ADDR_W-1:0];

   // Read-before-write: with L=1 the read returns the entry's old contents.
   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_mem[r_a] <= s_i;
         r_q        <= r_mem[w_ra];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_nx         <= '0;
         r_ny         <= '0;
         r_nz         <= '0;
         r_l          <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_z          <= '0;
         r_a          <= '0;
         r_drain      <= '0;
         r_v1         <= 1'b0;
         r_m1         <= 1'b0;
         r_s1         <= '0;
         data_o       <= '0;
         en_o         <= 1'b0;
         frame_done_o <= 1'b0;
         cfg_err_o    <= 1'b0;
      end else begin
         r_v1         <= w_beat;
         en_o         <= r_v1;
         frame_done_o <= 1'b0;
         if (w_beat) begin
            r_s1 <= s_i;
            r_m1 <= r_y == '0 || w_xw;
         end
         if (r_v1) data_o <= {16'(r_m1 ? '0 : r_q), 16'(r_s1)};
         case (r_state)
            IDLE: if (start_i) begin
               cfg_err_o <= !w_legal;
               if (w_legal) begin
                  r_nx    <= Nx;
                  r_ny    <= Ny;
                  r_nz    <= Nz;
                  r_l     <= w_prod[ADDR_W:0];
                  r_x     <= '0;
                  r_y     <= '0;
                  r_z     <= '0;
                  r_a     <= '0;
                  r_state <= RUN;
               end
            end
            RUN: if (w_beat) begin
               r_x <= w_xw ? '0 : r_x + X_LEN'(1);
               if (w_xw) r_z <= w_zw ? '0 : r_z + Z_LEN'(1);
               if (w_xw && w_zw) r_y <= r_y + Y_LEN'(1);
               r_a <= w_ra;
               if (w_xw && w_zw && w_yw) begin
                  r_drain <= '0;
                  r_state <= DRAIN;
               end
            end
            // frame_done_o lands 3 cycles after the last en_o
            DRAIN: begin
               r_drain <= r_drain + 2'd1;
               if (r_drain == 2'd2) r_state <= DONE;
            end
            DONE: begin
               frame_done_o <= 1'b1;
               r_state      <= IDLE;
            end
         endcase
      end
   end
endmodule
